// File: rtl/ysyx_22051013_csr_unit_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR map, op encodings, control bit
// positions, mstatus fields and the RW/RS/RC merge.
package ysyx_22051013_csr_unit_pkg;

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMisa     = 12'h301;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMip      = 12'h344;
  localparam logic [11:0] CsrMcycle   = 12'hB00;
  localparam logic [11:0] CsrMinstret = 12'hB02;
  localparam logic [11:0] CsrMhartid  = 12'hF14;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  // Bit positions inside csr_ctl = {wr_ena, rd_ena, ecall, mret}
  localparam int unsigned CtlWrEna = 3;
  localparam int unsigned CtlRdEna = 2;
  localparam int unsigned CtlEcall = 1;
  localparam int unsigned CtlMret  = 0;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;

  localparam logic [63:0] MstatusRst   = 64'h1800;
  localparam logic [63:0] McauseEcallM = 64'd11;

  function automatic logic [63:0] csr_merge(input csr_op_e op, input logic [63:0] old_val,
                                            input logic [63:0] src);
    unique case (op)
      CsrOpRw: csr_merge = src;
      CsrOpRs: csr_merge = old_val | src;
      CsrOpRc: csr_merge = old_val & ~src;
      default: csr_merge = old_val;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22051013_csr_counter.sv
// 64-bit free-running counter with synchronous reset; a load overrides the increment.
module ysyx_22051013_csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_22051013_csr_unit.sv
// Machine-mode CSR file and trap controller: CSR read/modify/write, ecall/mret PC redirect,
// mcycle/minstret counters.
module ysyx_22051013_csr_unit
  import ysyx_22051013_csr_unit_pkg::*;
#(
  parameter logic [63:0] HARTID   = 64'd0,
  parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [3:0]  csr_ctl,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_src,
  input  logic [63:0] pc_i,
  output logic [63:0] csr_rdata,
  output logic        trap_valid,
  output logic [63:0] trap_pc,
  output logic        illegal_csr
);

  logic wr_ena, rd_ena, ecall, mret;
  assign wr_ena = csr_ctl[CtlWrEna];
  assign rd_ena = csr_ctl[CtlRdEna];
  assign ecall  = csr_ctl[CtlEcall];
  assign mret   = csr_ctl[CtlMret];

  logic        mie_bit_q, mpie_bit_q;
  logic [63:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle, minstret;
  logic [63:0] mstatus_val, raw_rdata, wdata;
  logic        mapped, read_only, do_write;

  // Only MIE/MPIE are stored; MPP is hardwired to M-mode.
  assign mstatus_val = MstatusRst | (64'(mpie_bit_q) << MstatusMpie)
                                  | (64'(mie_bit_q) << MstatusMie);

  always_comb begin
    raw_rdata = '0;
    mapped    = 1'b1;
    case (csr_addr)
      CsrMstatus:  raw_rdata = mstatus_val;
      CsrMisa:     raw_rdata = MISA_VAL;
      CsrMie:      raw_rdata = mie_q;
      CsrMtvec:    raw_rdata = mtvec_q;
      CsrMscratch: raw_rdata = mscratch_q;
      CsrMepc:     raw_rdata = mepc_q;
      CsrMcause:   raw_rdata = mcause_q;
      CsrMip:      raw_rdata = '0;
      CsrMcycle:   raw_rdata = mcycle;
      CsrMinstret: raw_rdata = minstret;
      CsrMhartid:  raw_rdata = HARTID;
      default:     mapped    = 1'b0;
    endcase
  end

  assign read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == CsrMisa);
  assign wdata     = csr_merge(csr_op_e'(csr_op), raw_rdata, csr_src);
  assign do_write  = inst_valid && wr_ena && !ecall && !mret && mapped && !read_only
                     && (csr_op != CsrOpNone);

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (inst_valid && ecall) begin
      mepc_q     <= pc_i;
      mcause_q   <= McauseEcallM;
      mpie_bit_q <= mie_bit_q;
      mie_bit_q  <= 1'b0;
    end else if (inst_valid && mret) begin
      mie_bit_q  <= mpie_bit_q;
      mpie_bit_q <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CsrMstatus: begin
          mie_bit_q  <= wdata[MstatusMie];
          mpie_bit_q <= wdata[MstatusMpie];
        end
        CsrMie:      mie_q      <= wdata;
        CsrMtvec:    mtvec_q    <= {wdata[63:2], 2'b00};
        CsrMscratch: mscratch_q <= wdata;
        CsrMepc:     mepc_q     <= {wdata[63:2], 2'b00};
        CsrMcause:   mcause_q   <= wdata;
        default:     ;
      endcase
    end
  end

  ysyx_22051013_csr_counter u_mcycle (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (1'b1),
    .load_i     (do_write && (csr_addr == CsrMcycle)),
    .load_val_i (wdata),
    .cnt_o      (mcycle)
  );

  ysyx_22051013_csr_counter u_minstret (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (inst_valid),
    .load_i     (do_write && (csr_addr == CsrMinstret)),
    .load_val_i (wdata),
    .cnt_o      (minstret)
  );

  always_comb begin
    csr_rdata   = '0;
    trap_valid  = 1'b0;
    trap_pc     = '0;
    illegal_csr = 1'b0;
    if (!rst) begin
      csr_rdata   = rd_ena ? raw_rdata : '0;
      illegal_csr = ((rd_ena || wr_ena) && !mapped) || (wr_ena && read_only);
      trap_valid  = inst_valid && (ecall || mret);
      if (inst_valid && ecall) begin
        trap_pc = {mtvec_q[63:2], 2'b00};
      end else if (inst_valid && mret) begin
        trap_pc = mepc_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_csr_unit.sv
// Scoreboard bench for the CSR unit: each step queues its expected outputs, a sampled copy of
// the DUT outputs is queued alongside, and each scenario task drains and compares both queues.
module tb_ysyx_22051013_csr_unit;

  localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic        tv;
    logic [63:0] tpc;
    logic        ill;
  } item_t;

  logic        clk, rst, inst_valid;
  logic [3:0]  csr_ctl;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_src, pc_i, csr_rdata, trap_pc;
  logic        trap_valid, illegal_csr;

  item_t exp_q[$];
  item_t obs_q[$];
  int    checks, failures;
  logic [63:0] mcyc, minst;

  ysyx_22051013_csr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .csr_ctl     (csr_ctl),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_src     (csr_src),
    .pc_i        (pc_i),
    .csr_rdata   (csr_rdata),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .illegal_csr (illegal_csr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [1:0] op, input logic [63:0] o,
                                        input logic [63:0] s);
    case (op)
      2'b01:   return s;
      2'b10:   return o | s;
      2'b11:   return o & ~s;
      default: return o;
    endcase
  endfunction

  // Drive one instruction, queue expected and observed outputs, advance one cycle.
  task automatic step(input string n, input logic iv, input logic [3:0] ctl,
                      input logic [1:0] op, input logic [11:0] a, input logic [63:0] s,
                      input logic [63:0] pc, input logic [63:0] e_rd, input logic e_tv,
                      input logic [63:0] e_tpc, input logic e_ill);
    item_t e, o;
    logic  wr;
    inst_valid = iv; csr_ctl = ctl; csr_op = op; csr_addr = a; csr_src = s; pc_i = pc;
    e.name = n; e.rd = e_rd; e.tv = e_tv; e.tpc = e_tpc; e.ill = e_ill;
    exp_q.push_back(e);
    #3;
    o.name = n; o.rd = csr_rdata; o.tv = trap_valid; o.tpc = trap_pc; o.ill = illegal_csr;
    obs_q.push_back(o);
    if (rst) begin
      mcyc = '0; minst = '0;
    end else begin
      wr = iv && ctl[3] && !ctl[1] && !ctl[0] && op != 2'b00;
      if (wr && a == 12'hB00) mcyc = merge(op, mcyc, s);
      else mcyc = mcyc + 64'd1;
      if (wr && a == 12'hB02) minst = merge(op, minst, s);
      else if (iv) minst = minst + 64'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    item_t e, o;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_hold", 1, 4'b0100, 0, 12'h300, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("rst_mcycle", 1, 4'b0100, 0, 12'hB00, 0, 0, mcyc, 0, 0, 0);
    step("rst_mstatus", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1800, 0, 0, 0);
    step("rst_mepc", 1, 4'b0100, 0, 12'h341, 0, 0, 0, 0, 0, 0);
    step("rst_misa", 1, 4'b0100, 0, 12'h301, 0, 0, MISA, 0, 0, 0);
    step("rst_mhartid", 1, 4'b0100, 0, 12'hF14, 0, 0, 0, 0, 0, 0);
    step("rst_minstret", 1, 4'b0100, 0, 12'hB02, 0, 0, minst, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_rw_mtvec();
    item_t e, o;
    step("mtvec_rw", 1, 4'b1100, 2'b01, 12'h305, 64'h8000_0103, 0, 0, 0, 0, 0);
    step("mtvec_rd", 1, 4'b0100, 0, 12'h305, 0, 0, 64'h8000_0100, 0, 0, 0);
    step("mepc_rw", 1, 4'b1100, 2'b01, 12'h341, 64'h1237, 0, 0, 0, 0, 0);
    step("mepc_rd", 1, 4'b0100, 0, 12'h341, 0, 0, 64'h1234, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_mstatus();
    item_t e, o;
    step("ms_rs8", 1, 4'b1100, 2'b10, 12'h300, 64'h8, 0, 64'h1800, 0, 0, 0);
    step("ms_rd1", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1808, 0, 0, 0);
    step("ms_rc8", 1, 4'b1100, 2'b11, 12'h300, 64'h8, 0, 64'h1808, 0, 0, 0);
    step("ms_rd2", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1800, 0, 0, 0);
    step("ms_rw_ones", 1, 4'b1100, 2'b01, 12'h300, ONES, 0, 64'h1800, 0, 0, 0);
    step("ms_rd3", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1888, 0, 0, 0);
    step("ms_rw0_nord", 1, 4'b1000, 2'b01, 12'h300, 0, 0, 0, 0, 0, 0);
    step("ms_rd4", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1800, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_trap();
    item_t e, o;
    step("tr_mie_on", 1, 4'b1100, 2'b10, 12'h300, 64'h8, 0, 64'h1800, 0, 0, 0);
    step("tr_ecall", 1, 4'b0010, 0, 12'h0, 0, 64'h8000_0040, 0, 1, 64'h8000_0100, 0);
    step("tr_mepc", 1, 4'b0100, 0, 12'h341, 0, 0, 64'h8000_0040, 0, 0, 0);
    step("tr_mcause", 1, 4'b0100, 0, 12'h342, 0, 0, 64'd11, 0, 0, 0);
    step("tr_ms_ecall", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1880, 0, 0, 0);
    step("tr_mret", 1, 4'b0001, 0, 12'h0, 0, 0, 0, 1, 64'h8000_0040, 0);
    step("tr_ms_mret", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1888, 0, 0, 0);
    step("tr_prio", 1, 4'b1111, 2'b01, 12'h305, 0, 64'h8000_0080, 64'h8000_0100, 1,
         64'h8000_0100, 0);
    step("tr_mtvec_kept", 1, 4'b0100, 0, 12'h305, 0, 0, 64'h8000_0100, 0, 0, 0);
    step("tr_mepc2", 1, 4'b0100, 0, 12'h341, 0, 0, 64'h8000_0080, 0, 0, 0);
    step("tr_ms_prio", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1880, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_counters();
    item_t e, o;
    step("cnt_wr_mcycle", 1, 4'b1100, 2'b01, 12'hB00, ONES, 0, mcyc, 0, 0, 0);
    step("cnt_mcycle_max", 1, 4'b0100, 0, 12'hB00, 0, 0, ONES, 0, 0, 0);
    step("cnt_mcycle_wrap", 1, 4'b0100, 0, 12'hB00, 0, 0, 64'd0, 0, 0, 0);
    step("cnt_wr_minstret", 1, 4'b1100, 2'b01, 12'hB02, 64'd100, 0, minst, 0, 0, 0);
    step("cnt_minstret_ld", 1, 4'b0100, 0, 12'hB02, 0, 0, 64'd100, 0, 0, 0);
    step("cnt_minstret_inc", 1, 4'b0100, 0, 12'hB02, 0, 0, 64'd101, 0, 0, 0);
    step("cnt_idle_mcyc0", 0, 4'b0100, 0, 12'hB00, 0, 0, mcyc, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("cnt_idle", 0, 4'b0000, 0, 12'h0, 0, 0, 0, 0, 0, 0);
    step("cnt_idle_mcyc1", 0, 4'b0100, 0, 12'hB00, 0, 0, mcyc, 0, 0, 0);
    step("cnt_idle_minst", 0, 4'b0100, 0, 12'hB02, 0, 0, 64'd102, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_illegal();
    item_t e, o;
    step("il_wr_hartid", 1, 4'b1100, 2'b01, 12'hF14, 64'd5, 0, 0, 0, 0, 1);
    step("il_rd_hartid", 1, 4'b0100, 0, 12'hF14, 0, 0, 0, 0, 0, 0);
    step("il_wr_7c0", 1, 4'b1100, 2'b01, 12'h7C0, 64'd5, 0, 0, 0, 0, 1);
    step("il_rd_7c0", 1, 4'b0100, 0, 12'h7C0, 0, 0, 0, 0, 0, 1);
    step("il_wr_misa", 1, 4'b1100, 2'b01, 12'h301, 0, 0, MISA, 0, 0, 1);
    step("il_rd_misa", 1, 4'b0100, 0, 12'h301, 0, 0, MISA, 0, 0, 0);
    step("il_wr_mip", 1, 4'b1100, 2'b01, 12'h344, ONES, 0, 0, 0, 0, 0);
    step("il_rd_mip", 1, 4'b0100, 0, 12'h344, 0, 0, 0, 0, 0, 0);
    step("il_wr_noiv", 0, 4'b1000, 2'b01, 12'h340, 64'hABCD, 0, 0, 0, 0, 0);
    step("il_rd_scr0", 1, 4'b0100, 0, 12'h340, 0, 0, 0, 0, 0, 0);
    step("il_wr_scr", 1, 4'b1000, 2'b01, 12'h340, 64'hABCD, 0, 0, 0, 0, 0);
    step("il_rd_scr1", 1, 4'b0100, 0, 12'h340, 0, 0, 64'hABCD, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    item_t e, o;
    rst = 1'b1;
    step("rm_wr_in_rst", 1, 4'b1100, 2'b01, 12'h340, 64'h1234, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("rm_scratch", 1, 4'b0100, 0, 12'h340, 0, 0, 0, 0, 0, 0);
    step("rm_mtvec", 1, 4'b0100, 0, 12'h305, 0, 0, 0, 0, 0, 0);
    step("rm_mstatus", 1, 4'b0100, 0, 12'h300, 0, 0, 64'h1800, 0, 0, 0);
    step("rm_mcycle", 1, 4'b0100, 0, 12'hB00, 0, 0, mcyc, 0, 0, 0);
    step("rm_minstret", 1, 4'b0100, 0, 12'hB02, 0, 0, minst, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL %s no output", e.name); end
      else begin
        o = obs_q.pop_front();
        if ({o.rd, o.tv, o.tpc, o.ill} !== {e.rd, e.tv, e.tpc, e.ill}) begin
          failures++;
          $display("FAIL %s got rd=%h tv=%b tpc=%h ill=%b want rd=%h tv=%b tpc=%h ill=%b",
                   e.name, o.rd, o.tv, o.tpc, o.ill, e.rd, e.tv, e.tpc, e.ill);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; mcyc = '0; minst = '0;
    rst = 1'b1; inst_valid = 1'b0; csr_ctl = '0; csr_op = '0; csr_addr = '0;
    csr_src = '0; pc_i = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rw_mtvec();
    test_mstatus();
    test_trap();
    test_counters();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
